imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Serial boot loader. It receives a framed program image one
//               byte at a time, assembles little-endian 32-bit words and
//               writes them into instruction memory. It checks the frame's
//               XOR checksum and holds the core in reset until the image is
//               verified.
//               Frame layout: 0xA5, LEN_LO, LEN_HI, 4*N data bytes,
//               then one checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int IMEM_WORDS = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [7:0]  c_SYNC    = 8'hA5;
    localparam logic [15:0] c_MAX_LEN = 16'(IMEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t      r_state;
    logic [7:0]  r_len_lo;
    logic [15:0] r_len;        // frame length in words
    logic [15:0] r_word_cnt;   // words completed in the current frame
    logic [1:0]  r_byte_idx;   // byte position inside the current word
    logic [23:0] r_word;       // lower three bytes of the word being built
    logic [7:0]  r_csum;       // running XOR of data bytes

    logic        w_accept;
    logic [15:0] w_len;
    logic        w_last_byte;

    assign w_accept    = byte_valid && byte_ready;
    assign w_len       = {byte_data, r_len_lo};
    assign w_last_byte = (r_byte_idx == 2'd3) && ((r_word_cnt + 16'd1) == r_len);

    // Frame-parsing FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len_lo   <= 8'd0;
            r_len      <= 16'd0;
            r_word_cnt <= 16'd0;
            r_byte_idx <= 2'd0;
            r_word     <= 24'd0;
            r_csum     <= 8'd0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            core_rst   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            // The write strobe lasts one cycle. The loader takes bytes in
            // every state except DONE. The CHECK branch below overrides
            // this default when the frame completes.
            imem_we    <= 1'b0;
            byte_ready <= (r_state != S_DONE);

            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        if (byte_data == c_SYNC) begin
                            r_state    <= S_LEN_LO;
                            r_csum     <= 8'd0;
                            r_word_cnt <= 16'd0;
                            r_byte_idx <= 2'd0;
                        end
                    end
                    S_LEN_LO: begin
                        r_len_lo <= byte_data;
                        r_state  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        r_len <= w_len;
                        if (w_len == 16'd0) begin
                            r_state <= S_CHECK;
                        end else if (w_len > c_MAX_LEN) begin
                            r_state  <= S_ERROR;
                            load_err <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_csum     <= r_csum ^ byte_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_word[7:0]   <= byte_data;
                            2'd1: r_word[15:8]  <= byte_data;
                            2'd2: r_word[23:16] <= byte_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= r_word_cnt[ADDR_W-1:0];
                                imem_wdata <= {byte_data, r_word};
                                r_word_cnt <= r_word_cnt + 16'd1;
                            end
                        endcase
                        if (w_last_byte) begin
                            r_state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (byte_data == r_csum) begin
                            r_state    <= S_DONE;
                            byte_ready <= 1'b0;
                            core_rst   <= 1'b0;
                            load_done  <= 1'b1;
                        end else begin
                            r_state  <= S_ERROR;
                            load_err <= 1'b1;
                        end
                    end
                    S_ERROR: begin
                        // A fresh sync restarts the frame. Words already
                        // written to memory are left untouched.
                        if (byte_data == c_SYNC) begin
                            r_state    <= S_LEN_LO;
                            load_err   <= 1'b0;
                            r_csum     <= 8'd0;
                            r_word_cnt <= 16'd0;
                            r_byte_idx <= 2'd0;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. It drives byte streams
//               (directed and random) and compares the observed memory writes
//               and final status against a frame-level reference parser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        load_done;
    logic        load_err;

    int n_chk = 0;
    int n_err = 0;

    imem_loader #(.IMEM_WORDS(64), .ADDR_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    // Observed memory writes
    logic [5:0]  got_addr[$];
    logic [31:0] got_data[$];

    // Record each write strobe, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst && imem_we) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
        end
    end

    // Reference-model results
    int          m_addr[$];
    logic [31:0] m_data[$];
    int          m_used;
    bit          m_done;
    bit          m_err;

    logic [7:0]  stim[$];
    logic [7:0]  f31[$] = '{8'hA5, 8'h03, 8'h00,
                            8'h93, 8'h00, 8'hA0, 8'h00,
                            8'h13, 8'h01, 8'h40, 8'h01,
                            8'hB3, 8'h81, 8'h20, 8'h00,
                            8'h72};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Frame-level parser. It finds the expected writes, the final status
    // and how many bytes the loader consumes (it stops taking bytes at
    // DONE).
    task automatic model_run(input logic [7:0] s[$]);
        int         i;
        int         n;
        int         len;
        bit         stop;
        logic [7:0] cs;
        i = 0;
        n = s.size();
        stop = 1'b0;
        m_addr.delete();
        m_data.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        m_used = n;
        while (!stop) begin
            while (i < n && s[i] != 8'hA5) i++;
            if (i >= n) begin
                stop = 1'b1;
            end else begin
                m_err = 1'b0;
                i++;
                if (i + 2 > n) begin
                    stop = 1'b1;
                end else begin
                    len = int'(s[i]) + 256 * int'(s[i+1]);
                    i += 2;
                    if (len > 64) begin
                        m_err = 1'b1;
                    end else begin
                        cs = 8'h00;
                        for (int k = 0; k < len && !stop; k++) begin
                            if (i + 4 > n) begin
                                stop = 1'b1;
                            end else begin
                                m_addr.push_back(k);
                                m_data.push_back({s[i+3], s[i+2], s[i+1], s[i]});
                                cs = cs ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
                                i += 4;
                            end
                        end
                        if (!stop) begin
                            if (i >= n) begin
                                stop = 1'b1;
                            end else if (s[i] == cs) begin
                                m_done = 1'b1;
                                i++;
                                m_used = i;
                                stop = 1'b1;
                            end else begin
                                m_err = 1'b1;
                                i++;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        w = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!byte_ready) chk("ready_timeout", {31'd0, byte_ready}, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_we",    {31'd0, imem_we},    32'd0);
        chk("rst_addr",  {26'd0, imem_addr},  32'd0);
        chk("rst_wdata", imem_wdata,          32'd0);
        chk("rst_core",  {31'd0, core_rst},   32'd1);
        chk("rst_done",  {31'd0, load_done},  32'd0);
        chk("rst_err",   {31'd0, load_err},   32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_addr.delete();
        got_data.delete();
        @(negedge clk);
        chk("ready_after_rst", {31'd0, byte_ready}, 32'd1);
    endtask

    task automatic run_stream(input string tag, input logic [7:0] s[$], input int maxgap);
        int nmin;
        model_run(s);
        for (int j = 0; j < m_used; j++) begin
            send_byte(s[j], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
        repeat (3) @(negedge clk);
        chk({tag, "_nwr"}, got_data.size(), m_data.size());
        nmin = (got_data.size() < m_data.size()) ? got_data.size() : m_data.size();
        for (int j = 0; j < nmin; j++) begin
            chk({tag, "_addr"}, {26'd0, got_addr[j]}, m_addr[j]);
            chk({tag, "_data"}, got_data[j], m_data[j]);
        end
        chk({tag, "_done"},  {31'd0, load_done},  {31'd0, m_done});
        chk({tag, "_err"},   {31'd0, load_err},   {31'd0, m_err});
        chk({tag, "_core"},  {31'd0, core_rst},   {31'd0, !m_done});
        chk({tag, "_ready"}, {31'd0, byte_ready}, {31'd0, !m_done});
        chk({tag, "_we"},    {31'd0, imem_we},    32'd0);
    endtask

    task automatic gen_random();
        int         nf;
        int         kind;
        int         len;
        logic [7:0] b;
        logic [7:0] cs;
        stim.delete();
        nf = $urandom_range(1, 3);
        for (int f = 0; f < nf; f++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                stim.push_back(b);
            end
            kind = $urandom_range(0, 3);
            stim.push_back(8'hA5);
            if (kind == 3) begin
                len = $urandom_range(65, 300);
                stim.push_back(8'(len));
                stim.push_back(8'(len >> 8));
            end else begin
                len = $urandom_range(0, 6);
                stim.push_back(8'(len));
                stim.push_back(8'h00);
                cs = 8'h00;
                for (int j = 0; j < 4 * len; j++) begin
                    b = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
                    stim.push_back(b);
                    cs = cs ^ b;
                end
                stim.push_back((kind == 2) ? (cs ^ 8'($urandom_range(1, 255))) : cs);
            end
        end
    endtask

    initial begin
        do_reset();

        // Nominal three-word program
        run_stream("nominal", f31, 0);

        // Bad checksum, then recovery with an empty frame
        do_reset();
        stim = f31;
        stim[stim.size() - 1] = 8'h73;
        stim.push_back(8'hA5); stim.push_back(8'h00);
        stim.push_back(8'h00); stim.push_back(8'h00);
        run_stream("badcs", stim, 0);

        // Over-long frame
        do_reset();
        stim = '{8'hA5, 8'h41, 8'h00};
        run_stream("toolong", stim, 0);

        // Leading junk and sync values inside data
        do_reset();
        stim = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
        run_stream("a5data", stim, 0);

        // Nominal frame with idle gaps between bytes
        do_reset();
        run_stream("gaps", f31, 5);

        // Reset mid-frame after six data bytes, then resend
        do_reset();
        for (int j = 0; j < 9; j++) send_byte(f31[j], 0);
        do_reset();
        run_stream("midrst", f31, 0);

        // Random frame mixtures
        for (int it = 0; it < 30; it++) begin
            do_reset();
            gen_random();
            run_stream("rand", stim, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
